// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b - bin over WIDTH bits, BITS_PER_CYCLE bits per clock.
// Define SERIAL_SUB_SAT_EN to clamp diff to 0 when the final borrow is set.
module serial_subtractor #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int K  = BITS_PER_CYCLE;
    localparam int N  = WIDTH / K;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || K < 1 || (WIDTH % K) != 0) begin : g_bad_cfg
            $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_borrow;
    logic             r_done;
    logic [K-1:0]     w_sa;
    logic [K-1:0]     w_sb;
    logic [K-1:0]     w_d;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_fin;

    assign w_sa   = r_a[r_cnt*K +: K];
    assign w_sb   = r_b[r_cnt*K +: K];
    assign w_last = (r_cnt == CW'(N - 1));

    // Ripple the borrow through the slice, one full subtractor per bit.
    always_comb begin
        w_d  = '0;
        w_bo = r_br;
        for (int i = 0; i < K; i++) begin
            w_d[i] = w_sa[i] ^ w_sb[i] ^ w_bo;
            w_bo   = (~w_sa[i] & w_sb[i]) | (~(w_sa[i] ^ w_sb[i]) & w_bo);
        end
    end

    always_comb begin
        w_res = r_res;
        w_res[r_cnt*K +: K] = w_d;
    end

`ifdef SERIAL_SUB_SAT_EN
    assign w_fin = w_bo ? '0 : w_res;
`else
    assign w_fin = w_res;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (start ? RUN : IDLE) : (w_last ? IDLE : RUN);
    end

    always_comb begin
        busy   = (r_state == RUN);
        done   = r_done;
        diff   = r_diff;
        borrow = r_borrow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && start) begin
                r_a   <= a;
                r_b   <= b;
                r_br  <= bin;
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_res <= w_res;
                r_br  <= w_bo;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) begin
                    r_diff   <= w_fin;
                    r_borrow <= w_bo;
                    r_done   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-bit subtractor computing `diff = a - b - bin` over `WIDTH` bits. It processes `BITS_PER_CYCLE` bits per clock through a registered borrow chain, so area trades against latency. It is the sequential, width-generalised successor to the 1-bit full subtractor and serves datapaths that need multi-bit subtraction with a start/done handshake. A `WIDTH=1`, `BITS_PER_CYCLE=1` instance is functionally a registered full subtractor.

## Interface
- `WIDTH`, 8, operand and result width in bits; must be ≥ 1.
- `BITS_PER_CYCLE`, 1, bits processed per RUN cycle; must divide `WIDTH`. A non-dividing value is an elaboration error.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when `busy`=0.
- `a` input `WIDTH`: minuend; latched on the accepting edge.
- `b` input `WIDTH`: subtrahend; latched on the accepting edge.
- `bin` input 1: borrow-in; latched on the accepting edge.
- `busy` output 1: operation in progress; `start` is ignored while high.
- `done` output 1: one-cycle pulse; `diff`/`borrow` are valid from this cycle.
- `diff` output `WIDTH`: result, held until the next `done`.
- `borrow` output 1: final borrow-out, held with `diff`.

## Operation
- Define N = `WIDTH`/`BITS_PER_CYCLE`.
- FSM states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
- IDLE → RUN on a clock edge where `start`=1 and `rst`=0. At that edge:
  - latch `a` and `b`;
  - load the borrow register with `bin`;
  - clear the slice counter to 0.
- Each RUN cycle, slice k (bits k·K .. k·K+K-1, LSB slice first) computes `a_k - b_k - br`, with K = `BITS_PER_CYCLE`.
  - Store the K-bit difference into the result register at slice k.
  - Update `br` with the slice borrow-out.
  - Per-bit logic is exactly the full-subtractor equations: d = a^b^br; bo = (~a&b) | (~(a^b)&br).
- After slice N-1 the FSM returns to IDLE at that edge. At the same edge:
  - load `diff` and `borrow` from the internal result and `br`;
  - register `done`=1 for exactly one cycle.
- Changes on `a`, `b` or `bin` during RUN have no effect.
- `start` while `busy`=1 is dropped; it is not queued.
- `start` during the `done` cycle is accepted, because `busy`=0 in that cycle.
- Arithmetic is unsigned, modulo 2^WIDTH. `borrow`=1 iff a < b + bin as unsigned integers.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow`=0, FSM=IDLE, counter=0, `br`=0.
- Reset takes priority over everything, including `start` on the same edge and RUN in progress. An aborted operation produces no `done`, and `diff`/`borrow` go to 0.
- Latency for an accepting edge E:
  - `busy`=1 from E to edge E+N.
  - `done`=1 and outputs updated in the cycle after edge E+N.
- Throughput: one operation per N+1 cycles when `start` is held high.
- `done` never asserts without a prior accepted `start`.
- `done` is never high for two consecutive cycles.

## Configuration
- `SERIAL_SUB_SAT_EN` defined: unsigned saturation.
  - When the final borrow is 1, `diff` is forced to 0.
  - `borrow` still reports 1.
  - Latency is unchanged.
- `SERIAL_SUB_SAT_EN` undefined: `diff` wraps modulo 2^WIDTH.

## Test plan
- `WIDTH`=1, K=1, all 8 combinations of a/b/bin → `diff`/`borrow` match the full-subtractor truth table (e.g. 0,1,1 → diff 0, borrow 1). Each `done` arrives 1 cycle after the accepting edge, i.e. in the cycle after edge E+1.
- `WIDTH`=8, K=1:
  - a=0x5A, b=0x3C, bin=0 → diff=0x1E, borrow=0. `done` arrives in the cycle after edge E+8.
  - a=0x80, b=0x7F, bin=1 → diff=0x00, borrow=0.
- `WIDTH`=8, a=0x00, b=0x01, bin=0:
  - without the macro → diff=0xFF, borrow=1;
  - with `SERIAL_SUB_SAT_EN` → diff=0x00, borrow=1.
- `WIDTH`=8, K=4, a=0x5A, b=0x3C → diff=0x1E. `done` arrives in the cycle after edge E+2. Repeat with `start` held high: second result 3 cycles after the first.
- Mid-RUN checks:
  - pulse `start` with new operands → ignored; the original result is returned.
  - assert `rst` at cycle 3 of RUN → `busy`=0 and `diff`=0 next cycle, and no `done` appears afterwards.
